// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined multiplier between
// NUM_REQ requesters; tags each grant so the product returns to its owner.
module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int P_WIDTH = 16,
  parameter int LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic [A_WIDTH-1:0]         mult_a,
  output logic [B_WIDTH-1:0]         mult_b,
  input  logic [P_WIDTH-1:0]         mult_p,
  input  logic                       mult_ovf,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic                       rsp_ovf,
  output logic                       idle
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int DEPTH = LATENCY + 1;

  typedef logic [PTR_W-1:0] idx_t;

  // Handshake: requester i transfers in a cycle where req_valid[i] and
  // req_ready[i] are both high; req_ready never depends on operand data.
  idx_t               ptr;
  idx_t               ptr_next;
  logic               grant_found;
  idx_t               grant_idx;
  logic [PTR_W:0]     cand;
  logic               transfer;
  logic [A_WIDTH-1:0] sel_a;
  logic [B_WIDTH-1:0] sel_b;

  logic [DEPTH-1:0]   tag_valid;
  idx_t               tag_idx [DEPTH];

  // Search from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
        cand = cand - (PTR_W + 1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
    if (rst || !en) begin
      grant_found = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign transfer = |(req_valid & req_ready);

  always_comb begin
    ptr_next = ptr;
    if (transfer) begin
      ptr_next = (grant_idx == idx_t'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == idx_t'(i)) begin
        sel_a = req_a[i*A_WIDTH +: A_WIDTH];
        sel_b = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  // Non-transfer cycles feed zeros so the multiplier inputs stay deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      mult_a <= '0;
      mult_b <= '0;
    end else begin
      ptr    <= ptr_next;
      mult_a <= transfer ? sel_a : '0;
      mult_b <= transfer ? sel_b : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
    end else begin
      tag_valid <= {tag_valid[DEPTH-2:0], transfer};
    end
  end

  // Owner indices are only meaningful alongside their valid bit.
  always_ff @(posedge clk) begin
    tag_idx[0] <= grant_idx;
    for (int k = 1; k < DEPTH; k++) begin
      tag_idx[k] <= tag_idx[k-1];
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_valid[DEPTH-1]) begin
      rsp_valid[tag_idx[DEPTH-1]] = 1'b1;
    end
  end

  assign rsp_p   = mult_p;
  assign rsp_ovf = mult_ovf;
  assign idle    = ~(|tag_valid) & ~transfer;

endmodule
